demux_rr_param: RTL and testbench
=================================

# demux_rr_param

Parametrised round-robin demultiplexer. Distributes a single WIDTH-bit valid/ready input stream across NUM_CH output channels in rotating order. Each channel has its own one-entry registered output buffer with per-channel backpressure. It replaces the fixed 4-bit, 2-output demux and sits between a single producer and NUM_CH independent consumers.

## Interface
- WIDTH, 4: data width in bits (1..32).
- NUM_CH, 2: number of output channels (2..16; non-power-of-two allowed).
- PTR_W, derived localparam = $clog2(NUM_CH): pointer width.

- clk  input  1  rising-edge clock, sole clock domain.
- reset_L  input  1  asynchronous, active-low reset; deassertion is synchronous to clk.
- data_in  input  WIDTH  input word.
- valid_in  input  1  data_in is valid.
- ready_in  output  1  block accepts data_in this cycle.
- data_out  output  NUM_CH*WIDTH  flattened; channel c occupies bits [c*WIDTH +: WIDTH].
- valid_out  output  NUM_CH  channel c holds a word.
- ready_out  input  NUM_CH  consumer c takes its word this cycle.
- ptr  output  PTR_W  next target channel in round-robin order.

## Operation
- Per channel c: holding register data_q[c] and flag valid_q[c]. data_out and valid_out are driven directly from these registers.
- Reset (reset_L=0, asynchronous): valid_out=0, data_out=0, ptr=0, ready_in=0 while reset is held.
- Channel c is "free" when !valid_q[c], or when valid_q[c] && ready_out[c] (draining this cycle).
- Target channel t = ptr (strict mode; see Configuration for the alternative).
- ready_in = free(t).
- Accept occurs when valid_in && ready_in. On accept:
  - data_q[t] <= data_in and valid_q[t] <= 1.
  - ptr <= (t == NUM_CH-1) ? 0 : t+1. Wrap is at NUM_CH-1, not at 2^PTR_W.
- Drain occurs when valid_q[c] && ready_out[c] and channel c is not reloaded in the same cycle: valid_q[c] <= 0. data_q[c] keeps its last value.
- Simultaneous drain and accept on the same channel: the new word is loaded and valid stays 1. No bubble.
- Stability: while valid_out[c]=1 and ready_out[c]=0, data_out[c] holds unchanged.
- valid_in=0: ptr does not change and no channel is written, regardless of ready_in.
- ready_out[c] asserted while valid_out[c]=0 is ignored.
- Reset mid-operation: all buffered words are discarded and ptr returns to 0 immediately.

## Timing
- Latency: a word accepted at edge k appears on data_out[t] with valid_out[t]=1 after edge k.
- Throughput: one word per cycle when consumers keep up.
- ready_in is combinational from ptr, valid_q and ready_out. It has no combinational dependence on valid_in or data_in.
- All other outputs are registers; there are no combinational paths from inputs to data_out or valid_out.
- First accept is possible on the first rising edge after reset_L rises.

## Configuration
- DEMUX_SKIP_BUSY_EN defined: work-conserving mode.
  - t = first free channel found searching circularly from ptr (ptr, ptr+1, ..., wrapping).
  - ready_in = OR of free(c) over all channels.
  - On accept, ptr <= t+1 with wrap.
  - A stalled consumer no longer blocks the input.
- DEMUX_SKIP_BUSY_EN undefined: strict round-robin as described in Operation. Input stalls until channel ptr is free. Word order across channels is exactly 0, 1, ..., NUM_CH-1, 0, ...

## Test plan
- Reset/idle, WIDTH=4, NUM_CH=2: assert reset_L=0 mid-stream → valid_out=00, data_out=0x00, ptr=0 immediately, with no wait for clk.
- Strict streaming, NUM_CH=2, ready_out=11: input 0xF, 0xA, 0x8, 0x3 on consecutive cycles → ch0 gets F then 8, ch1 gets A then 3, each one cycle after accept. ready_in stays 1.
- Wrap, NUM_CH=3: push 6 words 1..6 with all ready_out=1 → channels 0,1,2,0,1,2 receive them. ptr sequence 0,1,2,0,1,2,0; ptr never reaches 3.
- Backpressure, strict mode: ready_out[1]=0 and ch1 full, ptr=1 → ready_in=0. data_out[1] holds its value for the whole stall. Raising ready_out[1] gives ready_in=1 in the same cycle, and the new word loads without a bubble.
- Skip mode, DEMUX_SKIP_BUSY_EN, NUM_CH=3: ch1 full and stalled, ptr=1, push 0x5 → written to ch2, ptr=0. The next push 0x6 goes to ch0.
- Idle input: valid_in=0 for 4 cycles with free channels → ptr constant and valid_out unchanged, apart from drains.

Source files
------------

// File: rtl/demux_rr_param.sv
// demux_rr_param: round-robin demultiplexer from one valid/ready input stream
// into NUM_CH output channels, each with a one-entry registered buffer.
//
// Ports:
//   clk        rising-edge clock
//   reset_L    asynchronous active-low reset
//   data_in    input word (WIDTH bits)
//   valid_in   data_in is valid
//   ready_in   block accepts data_in this cycle
//   data_out   flattened channel words, channel c at [c*WIDTH +: WIDTH]
//   valid_out  per-channel word present
//   ready_out  per-channel consumer takes its word
//   ptr        next target channel in round-robin order
//
// Option macro: DEMUX_SKIP_BUSY_EN selects work-conserving mode, where the
// target is the first free channel searched circularly from ptr. When it is
// undefined the input waits for channel ptr (strict round-robin).
module demux_rr_param #(
    parameter int WIDTH = 4,
    parameter int NUM_CH = 2,
    localparam int PTR_W = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    valid_in,
    output logic                    ready_in,
    output logic [NUM_CH*WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]       valid_out,
    input  logic [NUM_CH-1:0]       ready_out,
    output logic [PTR_W-1:0]        ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_CH - 1);

    logic [NUM_CH-1:0][WIDTH-1:0] data_q;
    logic [NUM_CH-1:0]            valid_q;
    logic [PTR_W-1:0]             ptr_q;

    logic [NUM_CH-1:0] free;
    logic [NUM_CH-1:0] load;
    logic [PTR_W-1:0]  tgt;
    logic [PTR_W-1:0]  ptr_nxt;
    logic              tgt_ok;
    logic              accept;

    // A channel is free when empty or when its consumer drains it now.
    assign free = ~valid_q | ready_out;

`ifdef DEMUX_SKIP_BUSY_EN
    // Walk offsets from the far end back to zero so the nearest free
    // channel (smallest offset from ptr) is the one left in tgt.
    always_comb begin
        int idx;
        idx    = 0;
        tgt    = ptr_q;
        tgt_ok = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (free[idx]) begin
                tgt    = PTR_W'(idx);
                tgt_ok = 1'b1;
            end
        end
    end
`else
    // Compare rather than index so ptr codes above NUM_CH-1 never
    // address past the end of free.
    always_comb begin
        tgt    = ptr_q;
        tgt_ok = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ptr_q == PTR_W'(c)) begin
                tgt_ok = free[c];
            end
        end
    end
`endif

    // Held low during reset even though every channel reads as empty.
    assign ready_in = tgt_ok & reset_L;
    assign accept   = valid_in & ready_in;

    // Wrap at NUM_CH-1, which matters when NUM_CH is not a power of two.
    assign ptr_nxt = (tgt == LAST) ? '0 : tgt + PTR_W'(1);

    always_comb begin
        load = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            load[c] = accept && (tgt == PTR_W'(c));
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_q  <= '0;
            valid_q <= '0;
            ptr_q   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                // A reload wins over a drain: the channel stays valid
                // with the new word, so there is no bubble.
                if (load[c]) begin
                    data_q[c]  <= data_in;
                    valid_q[c] <= 1'b1;
                end else if (valid_q[c] && ready_out[c]) begin
                    valid_q[c] <= 1'b0;
                end
            end
            if (accept) begin
                ptr_q <= ptr_nxt;
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign ptr       = ptr_q;

endmodule

// File: tb/tb_demux_rr_param.sv
// tb_demux_rr_param: directed bench for demux_rr_param with a 2-channel
// and a 3-channel instance sharing clock and reset.
module tb_demux_rr_param;

    logic clk;
    logic reset_L;

    logic [3:0] a_data_in;
    logic       a_valid_in;
    logic       a_ready_in;
    logic [7:0] a_data_out;
    logic [1:0] a_valid_out;
    logic [1:0] a_ready_out;
    logic [0:0] a_ptr;

    logic [3:0]  b_data_in;
    logic        b_valid_in;
    logic        b_ready_in;
    logic [11:0] b_data_out;
    logic [2:0]  b_valid_out;
    logic [2:0]  b_ready_out;
    logic [1:0]  b_ptr;

    int n_tests = 0;
    int n_fail  = 0;

    demux_rr_param #(.WIDTH(4), .NUM_CH(2)) dut_a (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in   (a_data_in),
        .valid_in  (a_valid_in),
        .ready_in  (a_ready_in),
        .data_out  (a_data_out),
        .valid_out (a_valid_out),
        .ready_out (a_ready_out),
        .ptr       (a_ptr)
    );

    demux_rr_param #(.WIDTH(4), .NUM_CH(3)) dut_b (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in   (b_data_in),
        .valid_in  (b_valid_in),
        .ready_in  (b_ready_in),
        .data_out  (b_data_out),
        .valid_out (b_valid_out),
        .ready_out (b_ready_out),
        .ptr       (b_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pa(input logic [3:0] d, input logic exp_rdy);
        a_valid_in = 1'b1;
        a_data_in  = d;
        #1;
        chk("a_ready_in", 32'(a_ready_in), 32'(exp_rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic pb(input logic [3:0] d, input logic exp_rdy);
        b_valid_in = 1'b1;
        b_data_in  = d;
        #1;
        chk("b_ready_in", 32'(b_ready_in), 32'(exp_rdy));
        @(posedge clk);
        #1;
    endtask

    logic [1:0] wrap_ch  [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [1:0] wrap_ptr [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};

    initial begin
        reset_L     = 1'b0;
        a_data_in   = '0;
        a_valid_in  = 1'b0;
        a_ready_out = '0;
        b_data_in   = '0;
        b_valid_in  = 1'b0;
        b_ready_out = '0;

        // reset state, before any clock edge
        #2;
        chk("rst_a_valid", 32'(a_valid_out), 32'h0);
        chk("rst_a_data", 32'(a_data_out), 32'h00);
        chk("rst_a_ptr", 32'(a_ptr), 32'h0);
        chk("rst_b_ptr", 32'(b_ptr), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_a_ready_in", 32'(a_ready_in), 32'h0);
        chk("rst_b_ready_in", 32'(b_ready_in), 32'h0);
        #2;
        reset_L = 1'b1;

        // strict streaming on 2 channels
        a_ready_out = 2'b11;
        pa(4'hF, 1'b1);
        chk("s1_valid", 32'(a_valid_out), 32'h1);
        chk("s1_ch0", 32'(a_data_out[3:0]), 32'hF);
        chk("s1_ptr", 32'(a_ptr), 32'h1);
        pa(4'hA, 1'b1);
        chk("s2_valid", 32'(a_valid_out), 32'h2);
        chk("s2_ch1", 32'(a_data_out[7:4]), 32'hA);
        chk("s2_ptr", 32'(a_ptr), 32'h0);
        pa(4'h8, 1'b1);
        chk("s3_valid", 32'(a_valid_out), 32'h1);
        chk("s3_ch0", 32'(a_data_out[3:0]), 32'h8);
        chk("s3_ptr", 32'(a_ptr), 32'h1);
        pa(4'h3, 1'b1);
        chk("s4_valid", 32'(a_valid_out), 32'h2);
        chk("s4_data", 32'(a_data_out), 32'h38);
        chk("s4_ptr", 32'(a_ptr), 32'h0);
        a_valid_in = 1'b0;
        @(posedge clk);
        #1;
        chk("s5_valid", 32'(a_valid_out), 32'h0);
        chk("s5_ptr", 32'(a_ptr), 32'h0);

        // backpressure on channel 1
        a_ready_out = 2'b00;
        pa(4'h5, 1'b1);
        pa(4'h7, 1'b1);
        chk("bp_fill_valid", 32'(a_valid_out), 32'h3);
        chk("bp_fill_ptr", 32'(a_ptr), 32'h0);
        a_ready_out = 2'b01;
        pa(4'h9, 1'b1);
        chk("bp_reload_valid", 32'(a_valid_out), 32'h3);
        chk("bp_reload_ch0", 32'(a_data_out[3:0]), 32'h9);
        chk("bp_reload_ptr", 32'(a_ptr), 32'h1);
        a_valid_in = 1'b1;
        a_data_in  = 4'hC;
        #1;
        chk("bp_stall_ready", 32'(a_ready_in), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_ch1", 32'(a_data_out[7:4]), 32'h7);
            chk("bp_hold_ptr", 32'(a_ptr), 32'h1);
            chk("bp_hold_ready", 32'(a_ready_in), 32'h0);
        end
        chk("bp_hold_valid", 32'(a_valid_out), 32'h2);
        a_ready_out = 2'b11;
        #1;
        chk("bp_release_ready", 32'(a_ready_in), 32'h1);
        @(posedge clk);
        #1;
        chk("bp_release_ch1", 32'(a_data_out[7:4]), 32'hC);
        chk("bp_release_valid", 32'(a_valid_out), 32'h2);
        chk("bp_release_ptr", 32'(a_ptr), 32'h0);

        // reset in the middle of traffic
        a_ready_out = 2'b00;
        pa(4'h1, 1'b1);
        a_valid_in = 1'b0;
        chk("mr_pre_valid", 32'(a_valid_out), 32'h3);
        chk("mr_pre_ptr", 32'(a_ptr), 32'h1);
        reset_L = 1'b0;
        #2;
        chk("mr_valid", 32'(a_valid_out), 32'h0);
        chk("mr_data", 32'(a_data_out), 32'h00);
        chk("mr_ptr", 32'(a_ptr), 32'h0);
        reset_L = 1'b1;
        #1;

        // wrap on 3 channels
        b_ready_out = 3'b111;
        for (int i = 0; i < 6; i++) begin
            pb(4'(i + 1), 1'b1);
            chk("wrap_data", 32'(b_data_out[wrap_ch[i]*4 +: 4]), 32'(i + 1));
            chk("wrap_valid", 32'(b_valid_out), 32'(3'b001 << wrap_ch[i]));
            chk("wrap_ptr", 32'(b_ptr), 32'(wrap_ptr[i]));
        end

        // idle input
        b_valid_in  = 1'b0;
        b_ready_out = 3'b000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("idle_ptr", 32'(b_ptr), 32'h0);
            chk("idle_valid", 32'(b_valid_out), 32'h4);
        end

        // bring ch1 to full and stalled with ptr=1
        b_ready_out = 3'b101;
        pb(4'h4, 1'b1);
        chk("st1_valid", 32'(b_valid_out), 32'h1);
        chk("st1_ptr", 32'(b_ptr), 32'h1);
        pb(4'h9, 1'b1);
        chk("st2_valid", 32'(b_valid_out), 32'h2);
        chk("st2_ptr", 32'(b_ptr), 32'h2);
        pb(4'h2, 1'b1);
        chk("st3_valid", 32'(b_valid_out), 32'h6);
        chk("st3_ptr", 32'(b_ptr), 32'h0);
        pb(4'h3, 1'b1);
        chk("st4_valid", 32'(b_valid_out), 32'h3);
        chk("st4_ptr", 32'(b_ptr), 32'h1);

`ifdef DEMUX_SKIP_BUSY_EN
        pb(4'h5, 1'b1);
        chk("skip_ch2", 32'(b_data_out[11:8]), 32'h5);
        chk("skip_valid", 32'(b_valid_out), 32'h6);
        chk("skip_ptr", 32'(b_ptr), 32'h0);
        pb(4'h6, 1'b1);
        chk("skip_ch0", 32'(b_data_out[3:0]), 32'h6);
        chk("skip_valid2", 32'(b_valid_out), 32'h3);
        chk("skip_ptr2", 32'(b_ptr), 32'h1);
        chk("skip_ch1_hold", 32'(b_data_out[7:4]), 32'h9);
`else
        b_valid_in = 1'b1;
        b_data_in  = 4'h5;
        #1;
        chk("strict_ready", 32'(b_ready_in), 32'h0);
        @(posedge clk);
        #1;
        chk("strict_ptr", 32'(b_ptr), 32'h1);
        chk("strict_ch1", 32'(b_data_out[7:4]), 32'h9);
        chk("strict_valid", 32'(b_valid_out), 32'h2);
        b_ready_out = 3'b111;
        #1;
        chk("strict_release", 32'(b_ready_in), 32'h1);
        @(posedge clk);
        #1;
        chk("strict_ch1_new", 32'(b_data_out[7:4]), 32'h5);
        chk("strict_ptr2", 32'(b_ptr), 32'h2);
        chk("strict_valid2", 32'(b_valid_out), 32'h2);
`endif
        b_valid_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
